// File: rtl/icache_pkg.sv
// Shared types for the I-cache miss queue: entry state, entry
// bookkeeping and line-address helper.
package icache_pkg;

  typedef enum logic [1:0] {
    FREE,
    WAIT_ISSUE,
    WAIT_RESP,
    FILLED
  } state_e;

  typedef struct packed {
    state_e state;
    logic   discard;
  } entry_t;

  function automatic logic [63:0] line_addr(
    input logic [63:0] pa,
    input int          off_w
  );
    return pa & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_mq_cam.sv
// Fully associative line-address compare across all live,
// non-discarded queue entries.
module icache_mq_cam
  import icache_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int PA_W    = 34
) (
  input  logic [PA_W-1:0] i_addr,
  input  logic [PA_W-1:0] i_tags [ENTRIES],
  input  entry_t          i_meta [ENTRIES],
  output logic            o_hit
);

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_meta[i].state != FREE &&
          !i_meta[i].discard &&
          i_tags[i] == i_addr)
        o_hit = 1'b1;
    end
  end

endmodule

// File: rtl/icache_miss_queue.sv
// Multi-outstanding I-cache miss queue: merges duplicate misses,
// issues line requests to L2 in order and returns refills in order.
module icache_miss_queue
  import icache_pkg::*;
#(
  parameter int PA_W     = 34,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5,
  parameter int ENTRIES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_valid,
  output logic              o_miss_ready,
  input  logic [PA_W-1:0]   i_miss_pa,
  output logic              o_merge,
  output logic              o_l2_req_valid,
  input  logic              i_l2_req_ready,
  output logic [PA_W-1:0]   o_l2_req_addr,
  input  logic              i_l2_resp_valid,
  output logic              o_l2_resp_ready,
  input  logic [LINE_W-1:0] i_l2_resp_line,
  output logic              o_refill_valid,
  input  logic              i_refill_ready,
  output logic [PA_W-1:0]   o_refill_addr,
  output logic [LINE_W-1:0] o_refill_line,
  input  logic              i_flush,
  output logic              o_busy
);

  localparam int PW = $clog2(ENTRIES);
  localparam int CW = PW + 1;

  entry_t            r_meta [ENTRIES];
  logic [PA_W-1:0]   r_addr [ENTRIES];
  logic [LINE_W-1:0] r_line [ENTRIES];

  logic [PW-1:0] r_alloc, r_issue, r_resp, r_retire;
  logic [CW-1:0] r_count, w_nwi;

  logic [PA_W-1:0] w_la;
  logic w_hit, w_full, w_alloc;
  logic w_iss, w_rsp, w_ret;

  assign w_la = PA_W'(line_addr(64'(i_miss_pa), OFFSET_W));

  icache_mq_cam #(
    .ENTRIES (ENTRIES),
    .PA_W    (PA_W)
  ) u_cam (
    .i_addr (w_la),
    .i_tags (r_addr),
    .i_meta (r_meta),
    .o_hit  (w_hit)
  );

  assign w_full       = r_count == CW'(ENTRIES);
  assign o_miss_ready = !rst && !i_flush && (!w_full || w_hit);
  assign o_merge      = i_miss_valid && o_miss_ready && w_hit;
  assign w_alloc      = i_miss_valid && o_miss_ready && !w_hit;

  assign o_l2_req_valid = r_meta[r_issue].state == WAIT_ISSUE;
  assign o_l2_req_addr  = o_l2_req_valid ? r_addr[r_issue] : '0;
  assign w_iss          = o_l2_req_valid && i_l2_req_ready;

  assign o_l2_resp_ready = !rst && r_meta[r_resp].state == WAIT_RESP;
  assign w_rsp           = o_l2_resp_ready && i_l2_resp_valid;

  assign o_refill_valid = r_meta[r_retire].state == FILLED &&
                          !r_meta[r_retire].discard;
  assign o_refill_addr  = o_refill_valid ? r_addr[r_retire] : '0;
  assign o_refill_line  = o_refill_valid ? r_line[r_retire] : '0;
  // discarded lines drain from the head without waiting on the consumer
  assign w_ret = r_meta[r_retire].state == FILLED &&
                 (r_meta[r_retire].discard || i_refill_ready);

  assign o_busy = r_count != '0;

  always_comb begin
    w_nwi = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_meta[i].state == WAIT_ISSUE)
        w_nwi = w_nwi + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        r_meta[i] <= '{state: FREE, discard: 1'b0};
      r_alloc  <= '0;
      r_issue  <= '0;
      r_resp   <= '0;
      r_retire <= '0;
      r_count  <= '0;
    end else begin
      if (w_alloc) begin
        r_meta[r_alloc] <= '{state: WAIT_ISSUE, discard: 1'b0};
        r_addr[r_alloc] <= w_la;
        r_alloc         <= r_alloc + PW'(1);
      end
      if (w_iss) begin
        r_meta[r_issue].state <= WAIT_RESP;
        r_issue               <= r_issue + PW'(1);
      end
      if (w_rsp) begin
        r_meta[r_resp].state <= FILLED;
        r_line[r_resp]       <= i_l2_resp_line;
        r_resp               <= r_resp + PW'(1);
      end
      if (w_ret) begin
        r_meta[r_retire] <= '{state: FREE, discard: 1'b0};
        r_retire         <= r_retire + PW'(1);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_ret);
      // unissued misses vanish; in-flight ones finish silently
      if (i_flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          unique case (r_meta[i].state)
            WAIT_ISSUE:
              if (w_iss && PW'(i) == r_issue)
                r_meta[i].discard <= 1'b1;
              else
                r_meta[i].state <= FREE;
            WAIT_RESP:
              r_meta[i].discard <= 1'b1;
            FILLED:
              if (!(w_ret && PW'(i) == r_retire))
                r_meta[i].discard <= 1'b1;
            default: ;
          endcase
        end
        r_issue <= r_issue + PW'(w_iss);
        r_alloc <= r_issue + PW'(w_iss);
        r_count <= r_count - CW'(w_ret) - w_nwi + CW'(w_iss);
      end
    end
  end

endmodule

// File: tb/tb_icache_miss_queue.sv
// Randomized + directed bench for icache_miss_queue against a
// queue-based behavioural model of outstanding misses.
module tb_icache_miss_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid, miss_ready, merge;
  logic [33:0]  miss_pa;
  logic         req_valid, req_ready;
  logic [33:0]  req_addr;
  logic         resp_valid, resp_ready;
  logic [255:0] resp_line;
  logic         refill_valid, refill_ready;
  logic [33:0]  refill_addr;
  logic [255:0] refill_line;
  logic         flush, busy;

  always #5 clk = ~clk;

  icache_miss_queue dut (
    .clk             (clk),
    .rst             (rst),
    .i_miss_valid    (miss_valid),
    .o_miss_ready    (miss_ready),
    .i_miss_pa       (miss_pa),
    .o_merge         (merge),
    .o_l2_req_valid  (req_valid),
    .i_l2_req_ready  (req_ready),
    .o_l2_req_addr   (req_addr),
    .i_l2_resp_valid (resp_valid),
    .o_l2_resp_ready (resp_ready),
    .i_l2_resp_line  (resp_line),
    .o_refill_valid  (refill_valid),
    .i_refill_ready  (refill_ready),
    .o_refill_addr   (refill_addr),
    .o_refill_line   (refill_line),
    .i_flush         (flush),
    .o_busy          (busy)
  );

  // model: outstanding misses oldest first; st 0=unissued 1=issued 2=filled
  typedef struct {
    logic [33:0]  a;
    int           st;
    bit           d;
    logic [255:0] data;
  } mrec_t;
  mrec_t q[$];

  int n_pass = 0;
  int n_total = 0;

  localparam logic [255:0] D0 = 256'hfea5_0123_4567_89ab_cdef_0011_2233_4455_6677_8899_aabb_ccdd_eeff_1357_9bdf_b527;

  function automatic logic [33:0] la(logic [33:0] pa);
    return pa & ~34'h1f;
  endfunction

  function automatic int first_st(int s);
    for (int i = 0; i < q.size(); i++)
      if (q[i].st == s) return i;
    return -1;
  endfunction

  function automatic bit mhit(logic [33:0] x);
    for (int i = 0; i < q.size(); i++)
      if (!q[i].d && q[i].a == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready();
    return !rst && !flush && (q.size() < 4 || mhit(la(miss_pa)));
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // model update on each active edge
  int  u_iw, u_ir;
  bit  u_rdy, u_hit, u_ret;
  initial forever begin
    @(posedge clk);
    if (rst) q.delete();
    else begin
      u_iw  = first_st(0);
      u_ir  = first_st(1);
      u_rdy = m_ready();
      u_hit = mhit(la(miss_pa));
      u_ret = q.size() > 0 && q[0].st == 2 && (q[0].d || refill_ready);
      if (u_ir >= 0 && resp_valid) begin
        q[u_ir].st   = 2;
        q[u_ir].data = resp_line;
      end
      if (u_iw >= 0 && req_ready) q[u_iw].st = 1;
      if (u_ret) void'(q.pop_front());
      if (flush) begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].st == 0) q.delete(i);
        for (int i = 0; i < q.size(); i++) q[i].d = 1'b1;
      end else if (miss_valid && u_rdy && !u_hit) begin
        q.push_back('{a: la(miss_pa), st: 0, d: 1'b0, data: '0});
      end
    end
  end

  // compare process, away from the active edge
  int  c_iw;
  bit  c_rdy, c_hit, c_rv;
  initial forever begin
    @(negedge clk);
    c_rdy = m_ready();
    c_hit = mhit(la(miss_pa));
    chk("miss_ready", miss_ready, c_rdy);
    chk("merge", merge, miss_valid && c_rdy && c_hit);
    chk("resp_ready", resp_ready, !rst && first_st(1) >= 0);
    if (!rst) begin
      c_iw = first_st(0);
      c_rv = q.size() > 0 && q[0].st == 2 && !q[0].d;
      chk("req_valid", req_valid, c_iw >= 0);
      chk("req_addr", req_addr, c_iw >= 0 ? q[c_iw].a : 34'h0);
      chk("refill_valid", refill_valid, c_rv);
      chk("refill_addr", refill_addr, c_rv ? q[0].a : 34'h0);
      chk("refill_line", refill_line, c_rv ? q[0].data : 256'h0);
      chk("busy", busy, q.size() != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(logic [33:0] pa);
    miss_valid = 1'b1;
    miss_pa    = pa;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    miss_valid = 1'b0; miss_pa = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_line = '0;
    refill_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("lit_rst_ready", miss_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_ready", miss_ready, 1'b1);
    chk("lit_post_rst_busy", busy, 1'b0);
    chk("lit_post_rst_addr", req_addr, 34'h0);

    // single miss and merge
    miss(34'h234567abc);
    step();
    miss_valid = 1'b0;
    @(negedge clk);
    chk("lit_req_valid", req_valid, 1'b1);
    chk("lit_req_addr", req_addr, 34'h234567aa0);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    miss(34'h234567ab0);
    @(negedge clk);
    chk("lit_merge", merge, 1'b1);
    chk("lit_wait_resp", resp_ready, 1'b1);
    step();
    miss_valid = 1'b0;
    @(negedge clk);
    chk("lit_no_second_req", req_valid, 1'b0);
    resp_valid = 1'b1; resp_line = D0;
    step();
    resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_refill_valid", refill_valid, 1'b1);
    chk("lit_refill_addr", refill_addr, 34'h234567aa0);
    chk("lit_refill_line", refill_line, D0);
    step();
    @(negedge clk);
    chk("lit_idle", busy, 1'b0);

    // fill, then drain across the wrap
    for (int k = 0; k < 4; k++) begin
      miss(34'(k + 1) << 12);
      step();
    end
    miss(34'h5 << 12);
    @(negedge clk);
    chk("lit_full_ready", miss_ready, 1'b0);
    chk("lit_full_head", req_addr, 34'h1000);
    miss_valid = 1'b0;
    req_ready = 1'b1; resp_valid = 1'b1;
    repeat (14) begin resp_line = rnd256(); step(); end
    for (int k = 0; k < 4; k++) begin
      miss(34'(k + 9) << 12);
      resp_line = rnd256();
      step();
    end
    miss_valid = 1'b0;
    repeat (12) begin resp_line = rnd256(); step(); end
    @(negedge clk);
    chk("lit_wrap_idle", busy, 1'b0);

    // ordered responses under refill backpressure
    refill_ready = 1'b0;
    miss(34'h234567abc); step();
    miss(34'h256789abc); step();
    miss_valid = 1'b0;
    repeat (4) begin resp_line = rnd256(); step(); end
    resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_bp_resp_ready", resp_ready, 1'b0);
    chk("lit_bp_first", refill_addr, 34'h234567aa0);
    refill_ready = 1'b1;
    step();
    @(negedge clk);
    chk("lit_bp_second", refill_addr, 34'h256789aa0);
    step();

    // flush with one in flight and two unissued
    req_ready = 1'b0;
    miss(34'h300000040); step();
    req_ready = 1'b1;
    miss(34'h300000080); step();
    req_ready = 1'b0;
    miss(34'h3000000c0); step();
    miss(34'h300000100); flush = 1'b1;
    @(negedge clk);
    chk("lit_flush_refuse", miss_ready, 1'b0);
    step();
    flush = 1'b0; miss_valid = 1'b0;
    @(negedge clk);
    chk("lit_flush_noreq", req_valid, 1'b0);
    chk("lit_flush_busy", busy, 1'b1);
    resp_valid = 1'b1; resp_line = rnd256();
    step();
    resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_flush_norefill", refill_valid, 1'b0);
    step();
    @(negedge clk);
    chk("lit_flush_idle", busy, 1'b0);

    // reset with three occupied entries
    miss(34'h111111100); step();
    miss(34'h122222200); step();
    miss(34'h133333300); step();
    miss_valid = 1'b0; rst = 1'b1;
    step();
    @(negedge clk);
    chk("lit_rst_req", req_valid, 1'b0);
    chk("lit_rst_busy", busy, 1'b0);
    chk("lit_rst_refill", refill_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_ready_after", miss_ready, 1'b1);
    miss(34'h1444444ff); step();
    miss_valid = 1'b0;
    @(negedge clk);
    chk("lit_rst_new_req", req_addr, 34'h1444444e0);

    // random traffic
    repeat (4000) begin
      step();
      rst          = $urandom_range(0, 299) == 0;
      flush        = $urandom_range(0, 39) == 0;
      miss_valid   = $urandom_range(0, 1) == 1;
      miss_pa      = {$urandom_range(1, 6) == 1 ? 5'h1 : 5'(3'($urandom_range(0, 5))), 24'h0, 5'($urandom)};
      miss_pa      = {miss_pa[33:29], 24'($urandom_range(0, 3)), miss_pa[4:0]};
      req_ready    = $urandom_range(0, 9) < 7;
      resp_valid   = $urandom_range(0, 9) < 6;
      resp_line    = rnd256();
      refill_ready = $urandom_range(0, 9) < 7;
    end
    step();
    rst = 1'b0; flush = 1'b0; miss_valid = 1'b0;
    req_ready = 1'b1; resp_valid = 1'b1; refill_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("end_idle", busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
